// File: rtl/nettlp_eth_rx_parser_if.sv
// MAC RX beat stream in, PCIe TX FIFO write port out (slave = parser side).
// The stream has no ready; the FIFO side offers only a prog_full hint.
`timescale 1ns/1ps
interface nettlp_eth_rx_parser_if;
  logic        eth_rx_tvalid;
  logic [63:0] eth_rx_tdata;
  logic [7:0]  eth_rx_tkeep;
  logic        eth_rx_tlast;
  logic        eth_rx_tuser;
  logic        fifo_prog_full;
  logic        fifo_wr_en;
  logic [78:0] fifo_din;

  modport slave (
    input  eth_rx_tvalid, eth_rx_tdata, eth_rx_tkeep, eth_rx_tlast, eth_rx_tuser,
    input  fifo_prog_full,
    output fifo_wr_en, fifo_din
  );

  modport master (
    output eth_rx_tvalid, eth_rx_tdata, eth_rx_tkeep, eth_rx_tlast, eth_rx_tuser,
    output fifo_prog_full,
    input  fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/nettlp_eth_rx_parser.sv
// NetTLP RX decapsulator: checks the 48-byte Eth/IPv4/UDP/NetTLP header and forwards TLP qwords.
// FIFO write lands 1 cycle after its input beat; no backpressure, frames are dropped on prog_full.
`timescale 1ns/1ps
module nettlp_eth_rx_parser #(
  parameter logic [31:0] LOCAL_IP        = 32'hC0A80A01,
  parameter logic [3:0]  PORT_CPL_NIBBLE = 4'h3,
  parameter logic [3:0]  PORT_MR_NIBBLE  = 4'h4
) (
  input  logic                         clk156,
  input  logic                         sys_rst,
  nettlp_eth_rx_parser_if.slave        bus,
  output logic                         tlp_is_cpl,
  output logic [15:0]                  tlp_seq,
  output logic [31:0]                  tlp_tstamp,
  output logic [31:0]                  cnt_rx_ok,
  output logic [31:0]                  cnt_drop_filter,
  output logic [31:0]                  cnt_drop_full,
  output logic [31:0]                  cnt_runt
);

  typedef enum logic [1:0] {SYNC, HDR, PAYLOAD, DROP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  qcnt;
  logic [15:0] h_proto;
  logic [3:0]  ip_version;
  logic [3:0]  ip_ihl;
  logic [7:0]  ip_protocol;
  logic [15:0] daddr0;
  logic [15:0] daddr1;
  logic [3:0]  dest_nibble;
  logic        hdr_ok;
  logic        take_payload;
  logic        inc_ok, inc_filter, inc_full, inc_runt;
  logic        vld, last;

  assign vld  = bus.eth_rx_tvalid;
  assign last = bus.eth_rx_tlast;

  // Fields from qwords 1..4 are already latched when qword 5 is on the bus.
  assign hdr_ok = (h_proto == 16'h0800) && (ip_version == 4'd4) && (ip_ihl == 4'd5) &&
                  (ip_protocol == 8'd17) && ({daddr0, daddr1} == LOCAL_IP) &&
                  ((dest_nibble == PORT_CPL_NIBBLE) || (dest_nibble == PORT_MR_NIBBLE));

  always_ff @(posedge clk156) begin
    if (sys_rst) state <= SYNC;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    take_payload = 1'b0;
    inc_ok       = 1'b0;
    inc_filter   = 1'b0;
    inc_full     = 1'b0;
    inc_runt     = 1'b0;
    case (state)
      // An idle cycle or a tlast beat marks a frame boundary.
      SYNC: if (!vld || last) state_nxt = HDR;
      HDR: begin
        if (vld) begin
          if (last) begin
            inc_runt = 1'b1;
          end else if (qcnt == 3'd5) begin
            if (!hdr_ok) begin
              state_nxt  = DROP;
              inc_filter = 1'b1;
            end else if (bus.fifo_prog_full) begin
              state_nxt = DROP;
              inc_full  = 1'b1;
            end else begin
              state_nxt    = PAYLOAD;
              take_payload = 1'b1;
            end
          end
        end
      end
      PAYLOAD: begin
        if (vld && last) begin
          state_nxt = HDR;
          inc_ok    = 1'b1;
        end
      end
      DROP:    if (vld && last) state_nxt = HDR;
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      qcnt            <= 3'd0;
      h_proto         <= 16'd0;
      ip_version      <= 4'd0;
      ip_ihl          <= 4'd0;
      ip_protocol     <= 8'd0;
      daddr0          <= 16'd0;
      daddr1          <= 16'd0;
      dest_nibble     <= 4'd0;
      tlp_is_cpl      <= 1'b0;
      tlp_seq         <= 16'd0;
      tlp_tstamp      <= 32'd0;
      cnt_rx_ok       <= 32'd0;
      cnt_drop_filter <= 32'd0;
      cnt_drop_full   <= 32'd0;
      cnt_runt        <= 32'd0;
      bus.fifo_wr_en  <= 1'b0;
      bus.fifo_din    <= 79'd0;
    end else begin
      if (state == HDR && vld) begin
        qcnt <= (last || qcnt == 3'd5) ? 3'd0 : qcnt + 3'd1;
        case (qcnt)
          3'd1: begin
            h_proto    <= bus.eth_rx_tdata[31:16];
            ip_version <= bus.eth_rx_tdata[15:12];
            ip_ihl     <= bus.eth_rx_tdata[11:8];
          end
          3'd2: ip_protocol <= bus.eth_rx_tdata[7:0];
          3'd3: daddr0 <= bus.eth_rx_tdata[15:0];
          3'd4: begin
            daddr1      <= bus.eth_rx_tdata[63:48];
            dest_nibble <= bus.eth_rx_tdata[31:28];
          end
          default: ;
        endcase
      end else if (state != HDR) begin
        qcnt <= 3'd0;
      end

      if (take_payload) begin
        tlp_is_cpl <= (dest_nibble == PORT_CPL_NIBBLE);
        tlp_seq    <= bus.eth_rx_tdata[47:32];
        tlp_tstamp <= bus.eth_rx_tdata[31:0];
      end

      if (inc_ok)     cnt_rx_ok       <= cnt_rx_ok + 32'd1;
      if (inc_filter) cnt_drop_filter <= cnt_drop_filter + 32'd1;
      if (inc_full)   cnt_drop_full   <= cnt_drop_full + 32'd1;
      if (inc_runt)   cnt_runt        <= cnt_runt + 32'd1;

      // Dword swap turns wire order into the PCIe core's little-endian dword order.
      bus.fifo_wr_en <= (state == PAYLOAD) && vld;
      if (state == PAYLOAD && vld) begin
        bus.fifo_din <= {1'b1, 1'b1, last,
                         bus.eth_rx_tkeep[3:0], bus.eth_rx_tkeep[7:4],
                         bus.eth_rx_tdata[31:0], bus.eth_rx_tdata[63:32],
                         last & bus.eth_rx_tuser, 3'b000};
      end
    end
  end

endmodule
